// File: rtl/core_fetch_pkg.sv
`default_nettype none
// ============================================================================
// rv : shared core types (instruction word, fetch entry) and PC helpers
// Revision: 1.0
// ============================================================================
package rv;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        logic [31:0] pc;
        instr_t      ir;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_fetch_fifo.sv
`default_nettype none
// ============================================================================
// core_fetch_fifo : instruction buffer, circular storage with synchronous flush
// Revision: 1.0
// ============================================================================
module core_fetch_fifo
    import rv::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  fetch_entry_t                push_data_i,
    input  logic                        pop_i,
    output fetch_entry_t                head_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            // Pointers wrap explicitly so non-power-of-two depths work.
            if (push_i) wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
            if (pop_i)  rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// core_fetch : credit-based instruction fetch with redirect and response drop
// Revision: 1.0
// ============================================================================
module core_fetch
    import rv::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output instr_t      out_ir,
    output logic [31:0] out_pc
);
    localparam int            FW     = $clog2(DEPTH + 1);
    localparam int            CW     = $clog2(2 * DEPTH + 1);
    localparam logic [CW-1:0] CREDIT = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [FW-1:0] buf_cnt;
    logic          req_fire, rsp_live, rsp_keep, pop;
    fetch_entry_t  push_entry, head;

    // Credit uses registered counts only: a pop this cycle frees space next cycle.
    assign imem_req_valid = rst_n && !redirect_valid
                            && ((outst_q + CW'(buf_cnt)) < CREDIT);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_live   = rst_n && imem_rsp_valid && (outst_q != '0);
    assign rsp_keep   = rsp_live && (drop_q == '0) && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, ir: imem_rsp_data};

    assign out_valid  = rst_n && (buf_cnt != '0) && !redirect_valid;
    assign pop        = out_valid && out_ready;
    assign out_ir     = head.ir;
    assign out_pc     = head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp_live);
        drop_d     = drop_q;
        if (rsp_live && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_STEP;
        // Everything still in flight after this cycle's response belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            rsp_pc_d   = align_pc(redirect_pc);
            drop_d     = outst_q - CW'(rsp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    core_fetch_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (buf_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
// tb_core_fetch : vector table, directed corner sequences and random traffic
// Revision: 1.0
// ============================================================================
module tb_core_fetch;
    import rv::*;

    localparam logic [31:0] RPC      = 32'h0000_0100;
    localparam int          TB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    instr_t      out_ir;
    logic [31:0] out_pc;

    core_fetch #(
        .RESET_PC       (RPC),
        .DEPTH          (TB_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Memory holds accepted requests tagged with the path (epoch) they were fetched on.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } mreq_t;

    typedef struct {
        bit          rstn, rd;
        logic [31:0] tgt;
        bit          rdy, ordy, rsp;
        bit          xrv;
        logic [31:0] xaddr;
        bit          xov;
        logic [31:0] xpc;
    } vec_t;

    mreq_t       mq[$];
    int          epoch = 0;
    int          buffered = 0;
    logic [31:0] exp_req = RPC;
    logic [31:0] exp_out = RPC;
    int          n_pass = 0, n_total = 0, cyc_no = 0;
    logic        s_rv, s_ov;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
    endtask

    // One clock: drive at negedge, sample and check against the model, then advance the model.
    task automatic step(input bit rstn, input bit rd, input logic [31:0] tgt,
                        input bit rdy, input bit ordy, input bit rsp, input bit junk);
        bit    have_rsp, exp_rv, exp_ov;
        mreq_t m;
        @(negedge clk);
        cyc_no++;
        rst_n          = rstn;
        redirect_valid = rd;
        redirect_pc    = tgt;
        imem_req_ready = rdy;
        out_ready      = ordy;
        have_rsp       = rstn && rsp && (mq.size() > 0);
        imem_rsp_valid = have_rsp || (junk && (mq.size() == 0 || !rstn));
        imem_rsp_data  = have_rsp ? mdata(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_ov = out_valid;      s_pc   = out_pc;
        exp_rv = rstn && !rd && ((mq.size() + buffered) < TB_DEPTH);
        exp_ov = rstn && !rd && (buffered != 0);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", out_pc, exp_out);
            chk("out_ir", out_ir, mdata(exp_out));
        end
        if (!rstn) begin
            mq.delete();
            buffered = 0;
            exp_req  = RPC;
            exp_out  = RPC;
            epoch++;
        end else begin
            if (have_rsp) begin
                m = mq.pop_front();
                if (m.epoch == epoch && !rd) buffered++;
            end
            if (exp_ov && ordy) begin
                buffered--;
                exp_out += 32'd4;
            end
            if (exp_rv && rdy) begin
                mq.push_back('{addr: exp_req, epoch: epoch});
                exp_req += 32'd4;
            end
            if (rd) begin
                epoch++;
                buffered = 0;
                exp_req  = tgt & ~32'd3;
                exp_out  = tgt & ~32'd3;
            end
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1);
    endtask

    task automatic wait_out(input string name, input logic [31:0] exp);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 0, 0, 1, 1, 1, 0);
            seen = s_ov;
        end
        chk({name, "_seen"}, s_ov, 1'b1);
        if (seen) chk(name, s_pc, exp);
    endtask

    function automatic vec_t mk(input bit rstn, input bit ordy,
                                input bit xrv, input logic [31:0] xaddr,
                                input bit xov, input logic [31:0] xpc);
        vec_t v;
        v.rstn = rstn; v.rd = 0; v.tgt = '0; v.rdy = 1; v.ordy = ordy; v.rsp = 1;
        v.xrv = xrv; v.xaddr = xaddr; v.xov = xov; v.xpc = xpc;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        int   nreq;
        bit   rd, prev_rd;
        logic [31:0] tgt;

        // Reset release with free-flowing decode, then decode stalled until credit runs out.
        vt.push_back(mk(0, 1, 0, 0,        0, 0));
        vt.push_back(mk(0, 1, 0, 0,        0, 0));
        vt.push_back(mk(1, 1, 1, 'h100,    0, 0));
        vt.push_back(mk(1, 1, 1, 'h104,    0, 0));
        vt.push_back(mk(1, 1, 1, 'h108,    1, 'h100));
        vt.push_back(mk(1, 1, 1, 'h10C,    1, 'h104));
        vt.push_back(mk(1, 1, 1, 'h110,    1, 'h108));
        vt.push_back(mk(0, 0, 0, 0,        0, 0));
        vt.push_back(mk(0, 0, 0, 0,        0, 0));
        vt.push_back(mk(1, 0, 1, 'h100,    0, 0));
        vt.push_back(mk(1, 0, 1, 'h104,    0, 0));
        vt.push_back(mk(1, 0, 1, 'h108,    1, 'h100));
        vt.push_back(mk(1, 0, 1, 'h10C,    1, 'h100));
        vt.push_back(mk(1, 0, 0, 0,        1, 'h100));
        vt.push_back(mk(1, 0, 0, 0,        1, 'h100));
        vt.push_back(mk(1, 1, 0, 0,        1, 'h100));
        vt.push_back(mk(1, 1, 1, 'h110,    1, 'h104));
        vt.push_back(mk(1, 1, 1, 'h114,    1, 'h108));
        vt.push_back(mk(1, 1, 1, 'h118,    1, 'h10C));
        vt.push_back(mk(1, 1, 1, 'h11C,    1, 'h110));

        foreach (vt[i]) begin
            step(vt[i].rstn, vt[i].rd, vt[i].tgt, vt[i].rdy, vt[i].ordy, vt[i].rsp, !vt[i].rstn);
            chk("vec_req_valid", s_rv, vt[i].xrv);
            if (vt[i].xrv) chk("vec_req_addr", s_addr, vt[i].xaddr);
            chk("vec_out_valid", s_ov, vt[i].xov);
            if (vt[i].xov) chk("vec_out_pc", s_pc, vt[i].xpc);
        end

        // Redirect to a misaligned target with two requests outstanding.
        do_reset();
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 1, 32'h2002, 1, 1, 0, 0);
        chk("redir_req_valid", s_rv, 1'b0);
        step(1, 0, 0, 1, 1, 1, 0);
        chk("redir_first_addr", s_addr, 32'h2000);
        wait_out("redir_first_pc", 32'h2000);

        // Redirect coinciding with a response and a pop.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 1, 0);
        step(1, 1, 32'h3000, 1, 1, 1, 0);
        chk("redir_pop_out_valid", s_ov, 1'b0);
        wait_out("redir_pop_first_pc", 32'h3000);

        // Fetch address wraps past the top of memory.
        do_reset();
        step(1, 1, 32'hFFFF_FFFC, 1, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 1, 1, 1, 0);
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        wait_out("wrap_pc", 32'hFFFF_FFFC);

        // Reset with three requests in flight; counters must restart from zero.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0);
        do_reset();
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 1, 0, 0);
            if (i == 0) chk("rst_first_addr", s_addr, RPC);
            if (s_rv) nreq++;
        end
        chk("rst_credit_reqs", nreq, TB_DEPTH);

        // Random traffic against the path/epoch model.
        do_reset();
        prev_rd = 0;
        for (int i = 0; i < 3000; i++) begin
            rd  = prev_rd ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 29) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(($urandom_range(0, 499) != 0), rd, tgt,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
            prev_rd = rd;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
